// File: rtl/sat_flip_ctrl_pkg.sv
// Shared types and width helpers for the 3SAT search controller.
package sat_pkg;

   typedef enum logic [2:0] {IDLE, RESTART, EVAL, CHECK, DONE} state_t;

   localparam int RAND_W = 32;

   // Ceiling log2, never below 1 so every derived vector has at least one bit.
   function automatic int clog2(input int x);
      int r;
      r = 1;
      while ((1 << r) < x) r++;
      return r;
   endfunction

   localparam int N_DEF         = 3;
   localparam int M_DEF         = 4;
   localparam int FLIPS_DEF     = 8;
   localparam int MAX_TRIES_DEF = 4;
   localparam int FC_W_DEF      = clog2(FLIPS_DEF + 1);
   localparam int TC_W_DEF      = clog2(MAX_TRIES_DEF + 1);

endpackage

// File: rtl/sat_flip_ctrl_if.sv
// Bus between the search controller and its random source / clause evaluator.
interface sat_flip_ctrl_if
   import sat_pkg::*;
#(
   parameter int N         = 3,
   parameter int M         = 4,
   parameter int FLIPS     = 8,
   parameter int MAX_TRIES = 4
);
   localparam int FC_W = clog2(FLIPS + 1);
   localparam int TC_W = clog2(MAX_TRIES + 1);

   logic                i_start;
   logic [RAND_W-1:0]   i_rand;
   logic [M-1:0]        i_clauses_sat;
   logic [M*N-1:0]      i_clause_vars;
   logic [N-1:0]        o_values;
   logic [N-1:0]        o_flip_mask;
   logic                o_busy;
   logic                o_done;
   logic                o_found;
   logic [FC_W-1:0]     o_flip_count;
   logic [TC_W-1:0]     o_try_count;

   modport master (
      output i_start, i_rand, i_clauses_sat, i_clause_vars,
      input  o_values, o_flip_mask, o_busy, o_done, o_found, o_flip_count, o_try_count
   );

   modport slave (
      input  i_start, i_rand, i_clauses_sat, i_clause_vars,
      output o_values, o_flip_mask, o_busy, o_done, o_found, o_flip_count, o_try_count
   );
endinterface

// File: rtl/sat_flip_ctrl_rfs.sv
// First set bit of a vector scanning upward from a start index with wrap-around.
module rotate_first_set
   import sat_pkg::*;
#(
   parameter int W = 4
) (
   input  logic [W-1:0]        i_vec,
   input  logic [clog2(W)-1:0] i_start,
   output logic [W-1:0]        o_onehot,
   output logic                o_found
);
   localparam int IW = clog2(W);

   logic [IW-1:0] w_idx;

   always_comb begin
      o_onehot = '0;
      o_found  = 1'b0;
      w_idx    = '0;
      for (int k = 0; k < W; k++) begin
         w_idx = IW'((32'(i_start) + 32'(k)) % W);
         if (!o_found && i_vec[w_idx]) begin
            o_onehot[w_idx] = 1'b1;
            o_found         = 1'b1;
         end
      end
   end
endmodule

// File: rtl/sat_flip_ctrl.sv
// WalkSAT-style search controller: proposes assignments, flips a variable from
// a randomly chosen unsatisfied clause, restarts after FLIPS flips.
module sat_flip_ctrl
   import sat_pkg::*;
#(
   parameter int N         = 3,
   parameter int M         = 4,
   parameter int FLIPS     = 8,
   parameter int MAX_TRIES = 4,
   parameter int EVAL_LAT  = 1
) (
   input  logic           clk,
   input  logic           reset,
   sat_flip_ctrl_if.slave bus
);
   localparam int FC_W = clog2(FLIPS + 1);
   localparam int TC_W = clog2(MAX_TRIES + 1);
   localparam int MI_W = clog2(M);
   localparam int NI_W = clog2(N);
   localparam int WT_W = clog2(EVAL_LAT);

   state_t          r_state;
   logic [N-1:0]    r_values;
   logic [N-1:0]    r_flip_mask;
   logic            r_busy;
   logic            r_done;
   logic            r_found;
   logic [FC_W-1:0] r_flip_cnt;
   logic [TC_W-1:0] r_try_cnt;
   logic [WT_W-1:0] r_wait;

   logic [M-1:0]    w_unsat;
   logic [MI_W-1:0] w_s;
   logic [NI_W-1:0] w_t;
   logic [M-1:0]    w_clause_oh;
   logic            w_clause_found;
   logic [N-1:0]    w_v;
   logic [N-1:0]    w_var_oh;
   logic            w_var_found;
   logic [N-1:0]    w_fm;

   assign w_unsat = ~bus.i_clauses_sat;
   assign w_s     = MI_W'(32'(bus.i_rand[15:0]) % M);
   assign w_t     = NI_W'(32'(bus.i_rand[31:16]) % N);

   rotate_first_set #(.W(M)) u_clause_pick (
      .i_vec    (w_unsat),
      .i_start  (w_s),
      .o_onehot (w_clause_oh),
      .o_found  (w_clause_found)
   );

   always_comb begin
      w_v = '0;
      for (int m = 0; m < M; m++) begin
         if (w_clause_found && w_clause_oh[m]) w_v = bus.i_clause_vars[m*N +: N];
      end
   end

   rotate_first_set #(.W(N)) u_var_pick (
      .i_vec    (w_v),
      .i_start  (w_t),
      .o_onehot (w_var_oh),
      .o_found  (w_var_found)
   );

   // An empty clause yields a zero mask: the flip is counted but changes nothing.
   assign w_fm = w_var_found ? w_var_oh : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_values    <= '0;
         r_flip_mask <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_found     <= 1'b0;
         r_flip_cnt  <= '0;
         r_try_cnt   <= '0;
         r_wait      <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.i_start) begin
                  r_state <= RESTART;
                  r_busy  <= 1'b1;
               end
            end
            RESTART: begin
               r_values    <= bus.i_rand[N-1:0];
               r_flip_cnt  <= '0;
               r_try_cnt   <= r_try_cnt + 1'b1;
               r_flip_mask <= '0;
               r_wait      <= WT_W'(EVAL_LAT - 1);
               r_state     <= EVAL;
            end
            EVAL: begin
               if (r_wait == '0) r_state <= CHECK;
               else              r_wait  <= r_wait - 1'b1;
            end
            CHECK: begin
               if (&bus.i_clauses_sat) begin
                  r_state <= DONE;
                  r_found <= 1'b1;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
               end else if (r_flip_cnt == FC_W'(FLIPS) && r_try_cnt == TC_W'(MAX_TRIES)) begin
                  r_state <= DONE;
                  r_found <= 1'b0;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
               end else if (r_flip_cnt == FC_W'(FLIPS)) begin
                  r_state <= RESTART;
               end else begin
                  r_values    <= r_values ^ w_fm;
                  r_flip_mask <= w_fm;
                  r_flip_cnt  <= r_flip_cnt + 1'b1;
                  r_wait      <= WT_W'(EVAL_LAT - 1);
                  r_state     <= EVAL;
               end
            end
            DONE: begin
               if (bus.i_start) begin
                  r_state   <= RESTART;
                  r_try_cnt <= '0;
                  r_done    <= 1'b0;
                  r_found   <= 1'b0;
                  r_busy    <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.o_values     = r_values;
   assign bus.o_flip_mask  = r_flip_mask;
   assign bus.o_busy       = r_busy;
   assign bus.o_done       = r_done;
   assign bus.o_found      = r_found;
   assign bus.o_flip_count = r_flip_cnt;
   assign bus.o_try_count  = r_try_cnt;
endmodule

// File: tb/tb_sat_flip_ctrl.sv
// Scoreboard bench for sat_flip_ctrl: expected search outcomes are queued at start.
module tb_sat_flip_ctrl;
   import sat_pkg::*;

   localparam int N         = 3;
   localparam int M         = 4;
   localparam int FLIPS     = 8;
   localparam int MAX_TRIES = 4;
   localparam int EVAL_LAT  = 1;

   typedef struct {
      logic       found;
      logic       chk_vals;
      logic [2:0] values;
      logic [2:0] tries;
      logic [3:0] flips;
      int         cycles;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   t0       = 0;
   exp_t sb_q[$];

   sat_flip_ctrl_if #(.N(N), .M(M), .FLIPS(FLIPS), .MAX_TRIES(MAX_TRIES)) u_if ();

   sat_flip_ctrl #(
      .N(N), .M(M), .FLIPS(FLIPS), .MAX_TRIES(MAX_TRIES), .EVAL_LAT(EVAL_LAT)
   ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic pulse_start();
      u_if.i_start = 1'b1;
      tick();
      u_if.i_start = 1'b0;
      t0 = cyc;
   endtask

   task automatic start_search(input exp_t e);
      sb_q.push_back(e);
      pulse_start();
   endtask

   task automatic wait_done(input string tag);
      exp_t e;
      while (!u_if.o_done && (cyc - t0) < 2000) tick();
      chk({tag, "_sb"}, 32'(sb_q.size()), 32'd1);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk({tag, "_done"},  32'(u_if.o_done), 32'd1);
         chk({tag, "_cycles"}, 32'(cyc - t0), 32'(e.cycles));
         chk({tag, "_found"}, 32'(u_if.o_found), 32'(e.found));
         chk({tag, "_tries"}, 32'(u_if.o_try_count), 32'(e.tries));
         chk({tag, "_flips"}, 32'(u_if.o_flip_count), 32'(e.flips));
         if (e.chk_vals) chk({tag, "_values"}, 32'(u_if.o_values), 32'(e.values));
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_values"}, 32'(u_if.o_values), 32'd0);
      chk({tag, "_mask"},   32'(u_if.o_flip_mask), 32'd0);
      chk({tag, "_busy"},   32'(u_if.o_busy), 32'd0);
      chk({tag, "_done"},   32'(u_if.o_done), 32'd0);
      chk({tag, "_found"},  32'(u_if.o_found), 32'd0);
      chk({tag, "_flips"},  32'(u_if.o_flip_count), 32'd0);
      chk({tag, "_tries"},  32'(u_if.o_try_count), 32'd0);
   endtask

   initial begin
      reset               = 1'b1;
      u_if.i_start        = 1'b0;
      u_if.i_rand         = '0;
      u_if.i_clauses_sat  = '0;
      u_if.i_clause_vars  = '0;
      tick();
      tick();
      chk_all_zero("rst");
      #2 reset = 1'b0;
      tick();

      // All clauses satisfied from the first assignment.
      u_if.i_rand        = 32'h0000_0005;
      u_if.i_clauses_sat = 4'b1111;
      start_search('{found:1'b1, chk_vals:1'b1, values:3'b101, tries:3'd1, flips:4'd0, cycles:3});
      chk("sat_busy", 32'(u_if.o_busy), 32'd1);
      tick();
      chk("sat_values", 32'(u_if.o_values), 32'h5);
      wait_done("sat");

      // One flip picks clause 2 (s=0) and variable 1 (t=1).
      u_if.i_rand        = 32'h0001_0000;
      u_if.i_clauses_sat = 4'b1011;
      u_if.i_clause_vars = {3'b001, 3'b110, 3'b001, 3'b001};
      start_search('{found:1'b1, chk_vals:1'b1, values:3'b010, tries:3'd1, flips:4'd1, cycles:5});
      tick();
      chk("flip_init_values", 32'(u_if.o_values), 32'h0);
      tick();
      tick();
      chk("flip_mask", 32'(u_if.o_flip_mask), 32'h2);
      chk("flip_values", 32'(u_if.o_values), 32'h2);
      chk("flip_count", 32'(u_if.o_flip_count), 32'd1);
      u_if.i_clauses_sat = 4'b1111;
      wait_done("flip");

      // Restart from DONE, chosen clause empty, start while busy ignored.
      u_if.i_rand        = 32'h0001_0002;
      u_if.i_clauses_sat = 4'b1011;
      u_if.i_clause_vars = {3'b001, 3'b000, 3'b001, 3'b001};
      start_search('{found:1'b1, chk_vals:1'b1, values:3'b010, tries:3'd1, flips:4'd1, cycles:5});
      chk("redo_busy", 32'(u_if.o_busy), 32'd1);
      chk("redo_done", 32'(u_if.o_done), 32'd0);
      chk("redo_found", 32'(u_if.o_found), 32'd0);
      chk("redo_tries_clr", 32'(u_if.o_try_count), 32'd0);
      tick();
      chk("redo_tries", 32'(u_if.o_try_count), 32'd1);
      chk("redo_values", 32'(u_if.o_values), 32'h2);
      u_if.i_start = 1'b1;
      tick();
      u_if.i_start = 1'b0;
      tick();
      chk("empty_mask", 32'(u_if.o_flip_mask), 32'h0);
      chk("empty_values", 32'(u_if.o_values), 32'h2);
      chk("empty_flips", 32'(u_if.o_flip_count), 32'd1);
      u_if.i_clauses_sat = 4'b1111;
      wait_done("empty");

      // Never satisfiable: exhaust every try.
      u_if.i_rand        = 32'h1234_5678;
      u_if.i_clauses_sat = 4'b0000;
      u_if.i_clause_vars = {3'b111, 3'b011, 3'b101, 3'b110};
      start_search('{found:1'b0, chk_vals:1'b0, values:3'b000, tries:3'd4, flips:4'd8, cycles:76});
      wait_done("unsat");
      for (int i = 0; i < 5; i++) tick();
      chk("unsat_hold_done", 32'(u_if.o_done), 32'd1);
      chk("unsat_hold_found", 32'(u_if.o_found), 32'd0);
      chk("unsat_hold_tries", 32'(u_if.o_try_count), 32'd4);

      // Asynchronous reset while in EVAL, then a cold start.
      u_if.i_rand        = 32'h0000_0007;
      u_if.i_clauses_sat = 4'b1111;
      pulse_start();
      tick();
      #2 reset = 1'b1;
      #1 chk_all_zero("areset");
      tick();
      chk("areset_busy", 32'(u_if.o_busy), 32'd0);
      #2 reset = 1'b0;
      tick();
      u_if.i_rand = 32'h0000_0006;
      start_search('{found:1'b1, chk_vals:1'b1, values:3'b110, tries:3'd1, flips:4'd0, cycles:3});
      wait_done("cold");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
